// File: rtl/two_op_mem_arbiter.sv
// rtl/two_op_mem_arbiter.sv - shares one single-port sync RAM between instruction fetch and data ports
// Optional ARB_RR_EN: round-robin on conflict instead of D-priority with a MAX_WAIT starvation guard.
module two_op_mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_valid,
  output logic [DW-1:0] i_data,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  owner_e        pend_owner;
  logic          pend_rd;
  logic [DW-1:0] i_data_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_win;

`ifdef ARB_RR_EN
  owner_e last_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_D;
    end else if (i_gnt) begin
      last_owner <= OWN_I;
    end else if (d_gnt) begin
      last_owner <= OWN_D;
    end
  end

  assign i_win = (last_owner == OWN_D);
`else
  localparam int              WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // D normally wins a conflict; a fetch refused MAX_WAIT times takes the next one.
  assign i_win = (wait_cnt == WAIT_MAX);
`endif

  // Grants are gated by reset so nothing reaches the RAM while reset is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (i_req && d_req) begin
        i_gnt = i_win;
        d_gnt = !i_win;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  assign mem_en    = i_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : i_addr;
  assign mem_wdata = d_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_owner <= OWN_NONE;
      pend_rd    <= 1'b0;
      i_data_q   <= '0;
      d_rdata_q  <= '0;
    end else begin
      pend_owner <= i_gnt ? OWN_I : (d_gnt ? OWN_D : OWN_NONE);
      pend_rd    <= i_gnt | (d_gnt & ~d_we);
      if (i_valid) i_data_q <= mem_rdata;
      if (d_valid && pend_rd) d_rdata_q <= mem_rdata;
    end
  end

  // RAM data is only present for one cycle, so the return cycle bypasses the holding register.
  assign i_valid = (pend_owner == OWN_I);
  assign d_valid = (pend_owner == OWN_D);
  assign i_data  = i_valid ? mem_rdata : i_data_q;
  assign d_rdata = (d_valid && pend_rd) ? mem_rdata : d_rdata_q;

endmodule
